// File: rtl/link_tx_unit.sv
// Flit and label types, plus the transmit end of an on/off-controlled link:
// a staging FIFO drained only while the registered downstream on_off reads "on".
package link_pkg;
    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t flit_label;
        logic [2:0]  x_dest;
        logic [2:0]  y_dest;
        logic [7:0]  payload;
    } flit_novc_t;
endpackage

// Purpose: stage upstream flits and forward them downstream under on/off control, checking framing.
// Latency: 2 cycles from accept to valid_o when on_q is already 1; 1 flit/cycle sustained.
// Backpressure: ready_o drops when the FIFO is full; off reaches valid_o after <=2 further pulses.
module link_tx_unit
    import link_pkg::*;
#(
    parameter int STAGE_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  flit_novc_t           data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 on_off_i,
    output flit_novc_t           data_o,
    output logic                 valid_o,
    output logic                 error_o,
    output logic                 is_idle_o,
    output logic [CNT_WIDTH-1:0] flit_cnt_o
);
    localparam int AW = (STAGE_DEPTH > 1) ? $clog2(STAGE_DEPTH) : 1;
    localparam int CW = $clog2(STAGE_DEPTH) + 1;

    typedef enum logic {IDLE, PACKET} chk_state_t;

    flit_novc_t    mem [STAGE_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          on_q;
    chk_state_t    state;
    logic          push;
    logic          send;

    assign ready_o   = (count != CW'(STAGE_DEPTH));
    assign push      = valid_i & ready_o;
    assign send      = on_q & (count != '0);
    assign is_idle_o = (count == '0) & ~valid_o & (state == IDLE);

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            on_q       <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            error_o    <= 1'b0;
            flit_cnt_o <= '0;
            state      <= IDLE;
        end else begin
            on_q    <= on_off_i;
            valid_o <= send;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (send) begin
                rd_ptr     <= rd_ptr + AW'(1);
                data_o     <= mem[rd_ptr];
                flit_cnt_o <= flit_cnt_o + CNT_WIDTH'(1);
            end
            case ({push, send})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Framing is judged on accepted flits; offending flits still go out unchanged.
            if (push) begin
                case (state)
                    IDLE: begin
                        case (data_i.flit_label)
                            HEAD:     state <= PACKET;
                            HEADTAIL: state <= IDLE;
                            default:  error_o <= 1'b1;
                        endcase
                    end
                    PACKET: begin
                        case (data_i.flit_label)
                            BODY:    state <= PACKET;
                            TAIL:    state <= IDLE;
                            HEAD:    error_o <= 1'b1;
                            default: begin
                                error_o <= 1'b1;
                                state   <= IDLE;
                            end
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_link_tx_unit.sv
// Directed self-checking bench for link_tx_unit (STAGE_DEPTH=4, CNT_WIDTH=4).
module tb_link_tx_unit;
    import link_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    flit_novc_t data_i;
    logic       valid_i;
    logic       ready_o;
    logic       on_off_i;
    flit_novc_t data_o;
    logic       valid_o;
    logic       error_o;
    logic       is_idle_o;
    logic [3:0] flit_cnt_o;

    int checks = 0;
    int errors = 0;

    link_tx_unit #(.STAGE_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .on_off_i  (on_off_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .error_o   (error_o),
        .is_idle_o (is_idle_o),
        .flit_cnt_o(flit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_novc_t mk(flit_label_t l, int x, int p);
        flit_novc_t f;
        f.flit_label = l;
        f.x_dest     = 3'(x);
        f.y_dest     = 3'(x + 1);
        f.payload    = 8'(p);
        return f;
    endfunction

    task automatic do_reset(input logic on);
        rst      = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        on_off_i = on;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error_o); end
        checks++; if (flit_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", flit_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++; if (is_idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", is_idle_o); end
    endtask

    task automatic test_packet();
        flit_label_t lbl [3] = '{HEAD, BODY, TAIL};
        do_reset(1'b1);
        tick();
        valid_i = 1'b1;
        data_i  = mk(HEAD, 1, 8'h11);
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL pkt_latency: got valid %b want 0", valid_o); end
        data_i = mk(BODY, 2, 8'h22);
        tick();
        checks++; if (valid_o !== 1'b1 || data_o.flit_label !== lbl[0] || data_o.x_dest !== 3'd1)
            begin errors++; $display("FAIL pkt_flit0: got v=%b %h want v=1 HEAD x=1", valid_o, data_o); end
        data_i = mk(TAIL, 3, 8'h33);
        tick();
        checks++; if (valid_o !== 1'b1 || data_o.flit_label !== lbl[1] || data_o.x_dest !== 3'd2)
            begin errors++; $display("FAIL pkt_flit1: got v=%b %h want v=1 BODY x=2", valid_o, data_o); end
        valid_i = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b1 || data_o.flit_label !== lbl[2] || data_o.x_dest !== 3'd3)
            begin errors++; $display("FAIL pkt_flit2: got v=%b %h want v=1 TAIL x=3", valid_o, data_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL pkt_end_valid: got %b want 0", valid_o); end
        checks++; if (flit_cnt_o !== 4'd3) begin errors++; $display("FAIL pkt_cnt: got %0d want 3", flit_cnt_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL pkt_error: got %b want 0", error_o); end
        checks++; if (is_idle_o !== 1'b1) begin errors++; $display("FAIL pkt_idle: got %b want 1", is_idle_o); end
    endtask

    task automatic test_fill_off();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = mk(HEADTAIL, i, 8'h40 + i);
            checks++; if (ready_o !== (i < 4)) begin errors++; $display("FAIL fill_ready%0d: got %b want %b", i, ready_o, (i < 4)); end
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fill_valid%0d: got %b want 0", i, valid_o); end
        end
        valid_i  = 1'b0;
        on_off_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL raise_early: got %b want 0", valid_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (valid_o !== 1'b1 || data_o.x_dest !== 3'(i))
                begin errors++; $display("FAIL drain%0d: got v=%b x=%0d want v=1 x=%0d", i, valid_o, data_o.x_dest, i); end
        end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_end: got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_back_to_back();
        flit_novc_t exp_q[$];
        flit_novc_t f;
        int seq = 0;
        int rcvd = 0;
        int bad = 0;
        int early = 0;
        int late = 0;
        int m = 10;
        do_reset(1'b1);
        tick();
        for (int c = 0; c < 38; c++) begin
            on_off_i = !(c >= m && c < m + 3);
            valid_i  = (c < 30);
            data_i   = mk(HEADTAIL, seq % 8, seq);
            if (valid_i && ready_o) begin
                exp_q.push_back(data_i);
                seq++;
            end
            tick();
            if (valid_o) begin
                rcvd++;
                if (exp_q.size() == 0) bad++;
                else begin
                    f = exp_q.pop_front();
                    if (data_o !== f) bad++;
                end
                if (c == m || c == m + 1) early++;
                if (c == m + 2 || c == m + 3) late++;
            end
        end
        checks++; if (early > 2) begin errors++; $display("FAIL off_slack: got %0d pulses want <=2", early); end
        checks++; if (late !== 0) begin errors++; $display("FAIL off_stop: got %0d pulses want 0", late); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stream_order: got %0d bad flits want 0", bad); end
        checks++; if (rcvd !== seq || exp_q.size() !== 0)
            begin errors++; $display("FAIL stream_count: got %0d rcvd want %0d", rcvd, seq); end
    endtask

    task automatic test_framing();
        do_reset(1'b1);
        tick();
        valid_i = 1'b1;
        data_i  = mk(BODY, 5, 8'h55);
        tick();
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL frame_body_err: got %b want 1", error_o); end
        valid_i = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b1 || data_o !== mk(BODY, 5, 8'h55))
            begin errors++; $display("FAIL frame_body_fwd: got v=%b %h want v=1 %h", valid_o, data_o, mk(BODY, 5, 8'h55)); end
        valid_i = 1'b1;
        data_i  = mk(HEAD, 1, 8'h61);
        tick();
        data_i = mk(HEAD, 2, 8'h62);
        tick();
        valid_i = 1'b0;
        repeat (3) tick();
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL frame_hh_err: got %b want 1", error_o); end
        checks++; if (is_idle_o !== 1'b0) begin errors++; $display("FAIL frame_hh_packet: got idle %b want 0", is_idle_o); end
        valid_i = 1'b1;
        data_i  = mk(TAIL, 3, 8'h63);
        tick();
        valid_i = 1'b0;
        repeat (3) tick();
        checks++; if (is_idle_o !== 1'b1) begin errors++; $display("FAIL frame_tail_idle: got %b want 1", is_idle_o); end
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL frame_sticky: got %b want 1", error_o); end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        valid_i  = 1'b0;
        on_off_i = 1'b1;
        tick();
        valid_i = 1'b1;
        data_i  = mk(HEAD, 1, 8'h71);
        tick();
        data_i = mk(BODY, 2, 8'h72);
        tick();
        data_i = mk(BODY, 3, 8'h73);
        tick();
        valid_i = 1'b0;
        rst     = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", valid_o); end
        checks++; if (flit_cnt_o !== 4'd0) begin errors++; $display("FAIL mrst_cnt: got %0d want 0", flit_cnt_o); end
        checks++; if (is_idle_o !== 1'b1) begin errors++; $display("FAIL mrst_idle: got %b want 1", is_idle_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL mrst_error: got %b want 0", error_o); end
        repeat (6) begin
            tick();
            if (valid_o) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mrst_ghost: got %0d flits want 0", seen); end
    endtask

    task automatic test_cnt_wrap();
        do_reset(1'b1);
        tick();
        valid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data_i = mk(HEADTAIL, i, i);
            tick();
        end
        valid_i = 1'b0;
        repeat (4) tick();
        checks++; if (flit_cnt_o !== 4'd1) begin errors++; $display("FAIL cnt_wrap: got %0d want 1", flit_cnt_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL cnt_wrap_err: got %b want 0", error_o); end
    endtask

    initial begin
        rst      = 1'b1;
        valid_i  = 1'b0;
        on_off_i = 1'b0;
        data_i   = '0;
        test_reset();
        test_packet();
        test_fill_off();
        test_back_to_back();
        test_framing();
        test_mid_reset();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/link_tx_unit.md
Name: link_tx_unit

Overview:
- Transmit end of the on/off-controlled link that feeds a downstream input-port circular_buffer.
- Accepts flit_novc_t flits from the local switch/crossbar side through a valid/ready handshake and stages them in a small FIFO.
- Drives the downstream buffer's write strobe only while the downstream on_off signal, registered once, reports "on".
- Also checks HEAD/BODY/TAIL packet framing, flags violations, and counts flits sent.

Parameters:
STAGE_DEPTH, 4, staging FIFO depth in flits; power of two, ≥2
CNT_WIDTH, 16, width of the sent-flit counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous reset, active-low (0 = reset)
data_i  input  flit_novc_t  flit from the upstream source
valid_i  input  1  data_i valid
ready_o  output  1  block can accept a flit this cycle
on_off_i  input  1  downstream on_off_o: 1 = on (may send), 0 = off
data_o  output  flit_novc_t  flit to the downstream buffer data_i
valid_o  output  1  write strobe to the downstream buffer write_i
error_o  output  1  sticky framing-violation flag
is_idle_o  output  1  FIFO empty, valid_o low, checker in IDLE
flit_cnt_o  output  CNT_WIDTH  number of flits sent, wraps

Behaviour:
- Reset values (rst=0 sampled at a rising edge):
  - FIFO emptied; read and write pointers = 0; count = 0.
  - on_q = 0; valid_o = 0; data_o = all zeros.
  - error_o = 0; flit_cnt_o = 0; checker state = IDLE.
  - ready_o and is_idle_o are combinational from state, so they read 1 once reset has been applied.
- Reset mid-operation: staged flits are discarded, and a partial packet is not completed. valid_o = 0 from the first cycle after the reset edge.
- Accept rule:
  - ready_o = (count != STAGE_DEPTH).
  - A push occurs at an edge where valid_i & ready_o.
  - When full, ready_o = 0 even if a pop happens in the same cycle; there is no fall-through.
- Flow control:
  - on_q <= on_off_i every edge, giving exactly one register stage.
  - Send condition = on_q & (count != 0).
  - When the send condition holds, the block pops the head at the edge, and in the next cycle data_o = popped flit and valid_o = 1.
  - Otherwise valid_o = 0 and data_o holds its last value.
- Latency: a flit accepted at the edge ending cycle k, into an empty FIFO with on_q = 1 during cycle k+1, is visible on data_o/valid_o in cycle k+2.
- Throughput: one flit per cycle while on_q stays 1.
- Off reaction: if on_off_i falls in cycle m, valid_o may still be high in cycles m+1 and m+2 and is low from m+3. The downstream buffer must reserve ≥2 free slots of slack when it deasserts on_off_o.
- Simultaneous push and pop: both take effect and count is unchanged. Pointers wrap modulo STAGE_DEPTH.
- Ordering: strict FIFO; flits are never reordered, duplicated or dropped except by reset.
- Framing checker: two states, IDLE and PACKET. It is evaluated on each accepted input flit using flit_label.
  - IDLE: HEAD -> PACKET; HEADTAIL -> IDLE; BODY or TAIL -> set error_o, stay IDLE.
  - PACKET: BODY -> PACKET; TAIL -> IDLE; HEAD -> set error_o, stay PACKET; HEADTAIL -> set error_o, go IDLE.
  - Violating flits are still forwarded unchanged.
  - error_o stays 1 until reset.
- flit_cnt_o: increments at every edge where a pop occurs, i.e. for every cycle valid_o goes high. It wraps from 2^CNT_WIDTH-1 to 0.
- is_idle_o = (count == 0) & ~valid_o & (state == IDLE).

Test Plan:
1. Reset then on_off_i = 1; push HEAD, BODY, TAIL in consecutive cycles (x_dest = 1, 2, 3) -> valid_o high in cycles k+2..k+4 with labels HEAD, BODY, TAIL in order; flit_cnt_o = 3; error_o = 0; is_idle_o = 1 afterwards.
2. on_off_i = 0 throughout; push STAGE_DEPTH+1 = 5 flits -> 4 accepted, ready_o = 0 on the 5th, valid_o never high; raise on_off_i -> 4 flits out on consecutive cycles starting 2 cycles after the raise; ready_o returns to 1.
3. Continuous stream with on_off_i = 1; drop on_off_i in cycle m for 3 cycles -> at most 2 valid_o pulses after m; zero in m+3..m+4; stream resumes with no flit lost or duplicated (scoreboard compare).
4. Push BODY while IDLE -> error_o = 1 next cycle and the flit is still delivered; push HEAD, HEAD -> error stays 1 and the checker stays PACKET.
5. Push 3 flits with on_off_i = 1, then assert rst = 0 for one edge -> valid_o = 0, flit_cnt_o = 0, is_idle_o = 1, error_o = 0; the previously staged flits never appear.
6. CNT_WIDTH = 4; send 17 HEADTAIL flits -> flit_cnt_o wraps to 1; error_o = 0.
